add_reservation_station: RTL
============================

Name: add_reservation_station

Overview:
Adder-side reservation station; receiver end of the dual-issue decode/dispatch interface, and the producer of the AR_Status full flag that dispatch throttles on.
- Accepts up to two decoded add/sub instructions per cycle with renamed operands.
- Snoops the common data bus (CDB) for missing operands.
- Hands one operand-complete entry per cycle to the adder FU.

Parameters:
DEPTH, 4, number of entries (>= 2)
DATA_W, 8, operand width
TAG_W, 3, producer tag width; tag 0 = operand already valid

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
disp1_valid  in  1  slot-1 dispatch request
disp1_op  in  8  opcode
disp1_tag  in  TAG_W  destination tag for this instruction
disp1_vj, disp1_vk  in  DATA_W  operand values (meaningful when matching q = 0)
disp1_qj, disp1_qk  in  TAG_W  operand producer tags
disp2_*  in  same set as disp1_*  slot-2 dispatch, program-order younger than slot 1
cdb_valid  in  1  result broadcast valid
cdb_tag  in  TAG_W  broadcasting producer tag
cdb_data  in  DATA_W  broadcast value
fu_ready  in  1  adder accepts an instruction this cycle
iss_valid  out  1  an entry is ready to issue
iss_op  out  8  issued opcode
iss_tag  out  TAG_W  issued destination tag
iss_vj, iss_vk  out  DATA_W  issued operands
AR_Status  out  1  1 = fewer than 2 free entries
free_count  out  $clog2(DEPTH+1)  free entries
overflow_err  out  1  sticky: dispatch arrived with no free slot

Behaviour:
Reset (async, rst_n low):
- All entries invalid.
- free_count = DEPTH, AR_Status = 0, iss_valid = 0, iss_* = 0, overflow_err = 0.
- Reset mid-operation drops all pending entries.

Status:
- AR_Status and free_count are decoded from registered state only; no dispatch-to-status combinational path.

Dispatch:
- Written at the clk edge.
- disp1 takes the lowest-index free entry; disp2 takes the next-lowest free entry.
- disp2 alone also takes the lowest-index free entry.
- A request with no free entry is dropped and sets overflow_err until reset.

Same-cycle CDB forwarding:
- If cdb_valid and a dispatching qj/qk equals cdb_tag (nonzero), the entry stores cdb_data with q = 0.

Wakeup:
- Every valid entry with qj or qk equal to a valid nonzero cdb_tag captures cdb_data into vj/vk and clears that q at the edge.
- An entry woken at edge M is issue-eligible in cycle M+1.
- Both operands may wake on the same broadcast.

Select (combinational from entry state):
- iss_valid = any valid entry with qj = 0 and qk = 0.
- The lowest-index such entry drives iss_*; iss_* hold 0 when iss_valid = 0.

Issue handshake:
- The entry is freed at the edge where iss_valid && fu_ready.
- With fu_ready = 0, the same entry stays presented and iss_* are stable.

Latency:
- Dispatch with both q = 0 at edge N gives iss_valid in cycle N+1.

Simultaneous events:
- A slot freed by issue at edge N is not reusable by dispatch at edge N; it counts in free_count from cycle N+1.
- Dispatch, wakeup and issue may all occur at the same edge.

Decomposition:
- Shared package (tomasulo_pkg): opcode constants OP_ADD = 8'h01 and OP_SUB = 8'h02, TAG_W, DATA_W, NULL_TAG = 0.
- Natural sub-module rs_priority_pick: parameterised find-first-set returning the index plus a found flag.
- rs_priority_pick is instantiated for free-slot allocation (twice, second with the first pick masked) and for issue selection.

Test Plan:
1. Reset, then disp1 op=01 tag=1 vj=3 vk=4 q=0 at edge 1, fu_ready=1 -> cycle 2: iss_valid=1, iss_tag=1, iss_vj=3, iss_vk=4; free_count back to 4 in cycle 3.
2. Dual dispatch each cycle, fu_ready=0, DEPTH=4 -> AR_Status=1 after the second dual dispatch. A third dual dispatch -> overflow_err=1 and free_count stays 0.
3. Dispatch qj=5, vk=2; after 3 cycles cdb_valid tag=5 data=9 -> next cycle iss_valid=1, iss_vj=9, iss_vk=2.
4. Dispatch qj=6 in the same cycle as cdb_valid tag=6 data=7 -> entry stored ready, issue next cycle with iss_vj=7.
5. Two ready entries at indices 0 and 2, fu_ready toggling 0/1 -> index 0 issues first and iss_* are stable while fu_ready=0; index 2 issues next.
6. Assert rst_n low mid-stream with 3 valid entries -> outputs immediately return to reset values; no issue after release.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared constants for the Tomasulo-style issue/execute slice: operand and tag
// widths, the null producer tag, and the adder opcodes.
package tomasulo_pkg;

    localparam int TAG_W  = 3;
    localparam int DATA_W = 8;

    localparam logic [TAG_W-1:0] NULL_TAG = '0;

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;

endpackage

// File: rtl/add_reservation_station_rs_priority_pick.sv
// Find-first-set: returns the lowest-index asserted request and whether any
// request is asserted at all.
module rs_priority_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);

    localparam int IDX_W = $clog2(N);

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Descending scan: the last hit written is the lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/add_reservation_station.sv
// Adder reservation station: dual dispatch in, CDB snoop for missing operands,
// one operand-complete entry per cycle out to the adder FU.
module add_reservation_station #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = tomasulo_pkg::DATA_W,
    parameter int TAG_W  = tomasulo_pkg::TAG_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       disp1_valid,
    input  logic [7:0]                 disp1_op,
    input  logic [TAG_W-1:0]           disp1_tag,
    input  logic [DATA_W-1:0]          disp1_vj,
    input  logic [DATA_W-1:0]          disp1_vk,
    input  logic [TAG_W-1:0]           disp1_qj,
    input  logic [TAG_W-1:0]           disp1_qk,
    input  logic                       disp2_valid,
    input  logic [7:0]                 disp2_op,
    input  logic [TAG_W-1:0]           disp2_tag,
    input  logic [DATA_W-1:0]          disp2_vj,
    input  logic [DATA_W-1:0]          disp2_vk,
    input  logic [TAG_W-1:0]           disp2_qj,
    input  logic [TAG_W-1:0]           disp2_qk,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    input  logic                       fu_ready,
    output logic                       iss_valid,
    output logic [7:0]                 iss_op,
    output logic [TAG_W-1:0]           iss_tag,
    output logic [DATA_W-1:0]          iss_vj,
    output logic [DATA_W-1:0]          iss_vk,
    output logic                       AR_Status,
    output logic [$clog2(DEPTH+1)-1:0] free_count,
    output logic                       overflow_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    function automatic logic cdb_hit(input logic v, input logic [TAG_W-1:0] ct,
                                     input logic [TAG_W-1:0] q);
        return v && (ct != '0) && (q == ct);
    endfunction

    logic [DEPTH-1:0]  valid_q;
    logic              overflow_q;
    logic [7:0]        op_q  [DEPTH];
    logic [TAG_W-1:0]  tag_q [DEPTH];
    logic [TAG_W-1:0]  qj_q  [DEPTH];
    logic [TAG_W-1:0]  qk_q  [DEPTH];
    logic [DATA_W-1:0] vj_q  [DEPTH];
    logic [DATA_W-1:0] vk_q  [DEPTH];

    logic [DEPTH-1:0] free_vec, free_vec2, ready_vec;
    logic [IDX_W-1:0] pick1_idx, pick2_idx, iss_idx;
    logic             pick1_found, pick2_found, iss_found;

    // Slots being issued this edge are still marked valid, so they are never
    // offered to dispatch until the following cycle.
    assign free_vec  = ~valid_q;
    assign free_vec2 = free_vec & ~(DEPTH'(1) << pick1_idx);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = valid_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
        end
    end

    rs_priority_pick #(.N(DEPTH)) u_pick_free1 (
        .req   (free_vec),
        .idx   (pick1_idx),
        .found (pick1_found)
    );

    rs_priority_pick #(.N(DEPTH)) u_pick_free2 (
        .req   (free_vec2),
        .idx   (pick2_idx),
        .found (pick2_found)
    );

    rs_priority_pick #(.N(DEPTH)) u_pick_iss (
        .req   (ready_vec),
        .idx   (iss_idx),
        .found (iss_found)
    );

    // Slot 2 falls back to the first free slot when slot 1 is idle.
    logic             alloc1_en, alloc2_en, overflow_set, iss_fire;
    logic [IDX_W-1:0] alloc2_idx;

    assign alloc1_en    = disp1_valid && pick1_found;
    assign alloc2_en    = disp2_valid && (disp1_valid ? pick2_found : pick1_found);
    assign alloc2_idx   = disp1_valid ? pick2_idx : pick1_idx;
    assign overflow_set = (disp1_valid && !pick1_found) || (disp2_valid && !alloc2_en);
    assign iss_fire     = iss_found && fu_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (iss_fire)     valid_q[iss_idx]    <= 1'b0;
            if (alloc1_en)    valid_q[pick1_idx]  <= 1'b1;
            if (alloc2_en)    valid_q[alloc2_idx] <= 1'b1;
            if (overflow_set) overflow_q          <= 1'b1;
        end
    end

    // NOTE: entry payload is not reset; valid_q alone decides whether a slot means anything.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && cdb_hit(cdb_valid, cdb_tag, qj_q[i])) begin
                vj_q[i] <= cdb_data;
                qj_q[i] <= '0;
            end
            if (valid_q[i] && cdb_hit(cdb_valid, cdb_tag, qk_q[i])) begin
                vk_q[i] <= cdb_data;
                qk_q[i] <= '0;
            end
        end
        if (alloc1_en) begin
            op_q[pick1_idx]  <= disp1_op;
            tag_q[pick1_idx] <= disp1_tag;
            vj_q[pick1_idx]  <= cdb_hit(cdb_valid, cdb_tag, disp1_qj) ? cdb_data : disp1_vj;
            vk_q[pick1_idx]  <= cdb_hit(cdb_valid, cdb_tag, disp1_qk) ? cdb_data : disp1_vk;
            qj_q[pick1_idx]  <= cdb_hit(cdb_valid, cdb_tag, disp1_qj) ? '0 : disp1_qj;
            qk_q[pick1_idx]  <= cdb_hit(cdb_valid, cdb_tag, disp1_qk) ? '0 : disp1_qk;
        end
        if (alloc2_en) begin
            op_q[alloc2_idx]  <= disp2_op;
            tag_q[alloc2_idx] <= disp2_tag;
            vj_q[alloc2_idx]  <= cdb_hit(cdb_valid, cdb_tag, disp2_qj) ? cdb_data : disp2_vj;
            vk_q[alloc2_idx]  <= cdb_hit(cdb_valid, cdb_tag, disp2_qk) ? cdb_data : disp2_vk;
            qj_q[alloc2_idx]  <= cdb_hit(cdb_valid, cdb_tag, disp2_qj) ? '0 : disp2_qj;
            qk_q[alloc2_idx]  <= cdb_hit(cdb_valid, cdb_tag, disp2_qk) ? '0 : disp2_qk;
        end
    end

    always_comb begin
        iss_op  = '0;
        iss_tag = '0;
        iss_vj  = '0;
        iss_vk  = '0;
        if (iss_found) begin
            iss_op  = op_q[iss_idx];
            iss_tag = tag_q[iss_idx];
            iss_vj  = vj_q[iss_idx];
            iss_vk  = vk_q[iss_idx];
        end
    end

    always_comb begin
        free_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i]) free_count = free_count + CNT_W'(1);
        end
    end

    assign iss_valid    = iss_found;
    assign AR_Status    = free_count < CNT_W'(2);
    assign overflow_err = overflow_q;

endmodule
